board_result_reader: RTL and testbench

- Reads the nine 2-bit board position values (00 empty, 01 player, 10 computer) that the position registers hold.
- On a start request it snapshots the board and scans the 8 winning lines sequentially, one per clock.
- Reports winner, winning line, draw and conflict with a one-cycle done pulse.
- Sits between the position register bank and the game-control FSM / display logic.

---
 rtl/board_result_reader.sv | 170 +++++++++++++++++
 tb/tb_board_result_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/board_result_reader.sv
// Tic-tac-toe board evaluator: snapshots nine cells on start and scans the 8 winning lines one per clock.
// Optional macro WIN_MASK_OUTPUT_EN adds a win_mask output marking the cells of the reported line.
module board_result_reader #(
  parameter bit STOP_ON_WIN = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [2:0] win_line,
  output logic       draw,
  output logic       conflict,
`ifdef WIN_MASK_OUTPUT_EN
  output logic [8:0] win_mask,
`endif
  output logic [1:0] state_dbg
);

  // Handshake: start is a level request taken only in ST_IDLE; busy covers SCAN and DONE,
  // done is a one-cycle pulse and results hold until the next accepted start.
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [8:0][1:0]  snap_q, snap_d;
  logic [2:0]       idx_q, idx_d;
  logic             scan_end_q, scan_end_d;
  logic [1:0]       winner_q, winner_d;
  logic [2:0]       win_line_q, win_line_d;
  logic             draw_q, draw_d;
  logic             conflict_q, conflict_d;
  logic [8:0]       mask_q, mask_d;

  // Cell membership of each winning line, bit n-1 for cell n.
  function automatic logic [8:0] line_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    line_mask = 9'b000000111;
      3'd1:    line_mask = 9'b000111000;
      3'd2:    line_mask = 9'b111000000;
      3'd3:    line_mask = 9'b001001001;
      3'd4:    line_mask = 9'b010010010;
      3'd5:    line_mask = 9'b100100100;
      3'd6:    line_mask = 9'b100010001;
      default: line_mask = 9'b001010100;
    endcase
  endfunction

  logic [8:0] cur_mask;
  logic [1:0] owner;
  logic       owned_p, owned_c;
  logic       any_empty;

  always_comb begin
    cur_mask  = line_mask(idx_q);
    owned_p   = 1'b1;
    owned_c   = 1'b1;
    any_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (cur_mask[i]) begin
        if (snap_q[i] != 2'b01) owned_p = 1'b0;
        if (snap_q[i] != 2'b10) owned_c = 1'b0;
      end
      if (snap_q[i] == 2'b00) any_empty = 1'b1;
    end
    owner = owned_p ? 2'b01 : (owned_c ? 2'b10 : 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    scan_end_d = scan_end_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    draw_d     = draw_q;
    conflict_d = conflict_q;
    mask_d     = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d     = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
          winner_d   = 2'b00;
          win_line_d = 3'd0;
          draw_d     = 1'b0;
          conflict_d = 1'b0;
          mask_d     = 9'd0;
          idx_d      = 3'd0;
          scan_end_d = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // The terminating line is evaluated one edge before DONE is entered.
        if (scan_end_q) begin
          draw_d  = (winner_q == 2'b00) && !any_empty;
          state_d = ST_DONE;
        end else begin
          if (owner != 2'b00) begin
            if (winner_q == 2'b00) begin
              winner_d   = owner;
              win_line_d = idx_q;
              mask_d     = cur_mask;
            end else if (!STOP_ON_WIN && (owner != winner_q)) begin
              conflict_d = 1'b1;
            end
          end
          if ((STOP_ON_WIN && (owner != 2'b00)) || (idx_q == 3'd7)) begin
            scan_end_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        scan_end_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      idx_q      <= 3'd0;
      scan_end_q <= 1'b0;
      winner_q   <= 2'b00;
      win_line_q <= 3'd0;
      draw_q     <= 1'b0;
      conflict_q <= 1'b0;
      mask_q     <= 9'd0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      scan_end_q <= scan_end_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      draw_q     <= draw_d;
      conflict_q <= conflict_d;
      mask_q     <= mask_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign winner    = winner_q;
  assign win_line  = win_line_q;
  assign draw      = draw_q;
  assign conflict  = conflict_q;
  assign state_dbg = state_q;
`ifdef WIN_MASK_OUTPUT_EN
  assign win_mask  = mask_q;
`else
  logic unused_mask;
  assign unused_mask = ^mask_q;
`endif

endmodule

// File: tb/tb_board_result_reader.sv
// Directed bench for board_result_reader: runs an early-stop (STOP_ON_WIN=1) and a full-scan
// (STOP_ON_WIN=0) instance side by side on the same board and start stimulus.
module tb_board_result_reader;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [1:0] pos [1:9];

  logic       busy1, done1, draw1, conflict1;
  logic [1:0] winner1, state1;
  logic [2:0] win_line1;
  logic       busy0, done0, draw0, conflict0;
  logic [1:0] winner0, state0;
  logic [2:0] win_line0;
`ifdef WIN_MASK_OUTPUT_EN
  logic [8:0] win_mask1, win_mask0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  board_result_reader #(.STOP_ON_WIN(1'b1)) dut_stop (
    .clock(clock), .reset_n(reset_n), .start(start),
    .pos1(pos[1]), .pos2(pos[2]), .pos3(pos[3]), .pos4(pos[4]), .pos5(pos[5]),
    .pos6(pos[6]), .pos7(pos[7]), .pos8(pos[8]), .pos9(pos[9]),
    .busy(busy1), .done(done1), .winner(winner1), .win_line(win_line1),
    .draw(draw1), .conflict(conflict1),
`ifdef WIN_MASK_OUTPUT_EN
    .win_mask(win_mask1),
`endif
    .state_dbg(state1)
  );

  board_result_reader #(.STOP_ON_WIN(1'b0)) dut_full (
    .clock(clock), .reset_n(reset_n), .start(start),
    .pos1(pos[1]), .pos2(pos[2]), .pos3(pos[3]), .pos4(pos[4]), .pos5(pos[5]),
    .pos6(pos[6]), .pos7(pos[7]), .pos8(pos[8]), .pos9(pos[9]),
    .busy(busy0), .done(done0), .winner(winner0), .win_line(win_line0),
    .draw(draw0), .conflict(conflict0),
`ifdef WIN_MASK_OUTPUT_EN
    .win_mask(win_mask0),
`endif
    .state_dbg(state0)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mk(input int p1, p2, p3, p4, p5, p6, p7, p8, p9);
    mk = {p9[1:0], p8[1:0], p7[1:0], p6[1:0], p5[1:0], p4[1:0], p3[1:0], p2[1:0], p1[1:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic set_board(input logic [17:0] brd);
    for (int i = 1; i <= 9; i++) pos[i] = brd[2*(i-1) +: 2];
  endtask

  // Launch one evaluation and watch both instances for 14 cycles after E0.
  // Cycle c is sampled on the falling edge after rising edge E<c>.
  task automatic run_case(input string tag, input logic [17:0] brd, input bit mutate,
                          input int lat1, input int lat0, input logic [1:0] exp_win,
                          input logic [2:0] exp_line, input logic exp_draw,
                          input logic exp_conf0, input logic [8:0] exp_mask);
    int got1, got0, cnt1, cnt0;
    logic [1:0] w1, w0;
    logic [2:0] l1, l0;
    logic d1, d0, c1, c0;
    logic [8:0] m1, m0;
    got1 = -1; got0 = -1; cnt1 = 0; cnt0 = 0;
    w1 = 'x; w0 = 'x; l1 = 'x; l0 = 'x; d1 = 'x; d0 = 'x; c1 = 'x; c0 = 'x;
    m1 = 'x; m0 = 'x;
    @(negedge clock);
    set_board(brd);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (c == 1) begin
        check({tag, " busy1"}, {31'd0, busy1}, 32'd1);
        check({tag, " busy0"}, {31'd0, busy0}, 32'd1);
      end
      if (mutate && c == 2) begin
        pos[1] = 2'b01; pos[2] = 2'b01; pos[3] = 2'b01;
        start = 1'b1;
      end
      if (mutate && c == 3) start = 1'b0;
      if (done1) begin
        cnt1++;
        if (got1 < 0) begin
          got1 = c; w1 = winner1; l1 = win_line1; d1 = draw1; c1 = conflict1;
`ifdef WIN_MASK_OUTPUT_EN
          m1 = win_mask1;
`endif
        end
      end
      if (done0) begin
        cnt0++;
        if (got0 < 0) begin
          got0 = c; w0 = winner0; l0 = win_line0; d0 = draw0; c0 = conflict0;
`ifdef WIN_MASK_OUTPUT_EN
          m0 = win_mask0;
`endif
        end
      end
    end
    check({tag, " latency1"}, got1, lat1);
    check({tag, " latency0"}, got0, lat0);
    check({tag, " done_count1"}, cnt1, 1);
    check({tag, " done_count0"}, cnt0, 1);
    check({tag, " winner1"}, {30'd0, w1}, {30'd0, exp_win});
    check({tag, " winner0"}, {30'd0, w0}, {30'd0, exp_win});
    if (exp_win != 2'b00) begin
      check({tag, " win_line1"}, {29'd0, l1}, {29'd0, exp_line});
      check({tag, " win_line0"}, {29'd0, l0}, {29'd0, exp_line});
    end
    check({tag, " draw1"}, {31'd0, d1}, {31'd0, exp_draw});
    check({tag, " draw0"}, {31'd0, d0}, {31'd0, exp_draw});
    check({tag, " conflict1"}, {31'd0, c1}, 32'd0);
    check({tag, " conflict0"}, {31'd0, c0}, {31'd0, exp_conf0});
`ifdef WIN_MASK_OUTPUT_EN
    check({tag, " win_mask1"}, {23'd0, m1}, {23'd0, exp_mask});
    check({tag, " win_mask0"}, {23'd0, m0}, {23'd0, exp_mask});
`else
    if (^exp_mask === 1'bx) check({tag, " mask_arg"}, 32'd0, 32'd1);
`endif
    // results must still be held long after done
    check({tag, " hold_winner1"}, {30'd0, winner1}, {30'd0, exp_win});
    check({tag, " hold_draw0"}, {31'd0, draw0}, {31'd0, exp_draw});
    check({tag, " idle_busy1"}, {31'd0, busy1}, 32'd0);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    start   = 1'b0;
    reset_n = 1'b0;
    set_board(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check("reset busy", {31'd0, busy1}, 32'd0);
    check("reset done", {31'd0, done0}, 32'd0);
    check("reset winner", {30'd0, winner1}, 32'd0);
    check("reset win_line", {29'd0, win_line0}, 32'd0);
    check("reset draw", {31'd0, draw1}, 32'd0);
    check("reset conflict", {31'd0, conflict0}, 32'd0);
    check("reset state", {30'd0, state1}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // reset mid-scan on an empty board
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("midscan busy before reset", {31'd0, busy0}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midscan busy1", {31'd0, busy1}, 32'd0);
    check("midscan busy0", {31'd0, busy0}, 32'd0);
    check("midscan state0", {30'd0, state0}, 32'd0);
    check("midscan winner", {30'd0, winner0}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clock);
        if (done1 || done0) dcnt++;
      end
      check("midscan no done", dcnt, 0);
    end

    run_case("player_row", mk(1, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0,
             2, 9, 2'b01, 3'd0, 1'b0, 1'b0, 9'b000000111);
    run_case("anti_diag", mk(0, 0, 2, 0, 2, 0, 2, 0, 0), 1'b0,
             9, 9, 2'b10, 3'd7, 1'b0, 1'b0, 9'b001010100);
    run_case("draw", mk(1, 2, 1, 1, 2, 2, 2, 1, 1), 1'b0,
             9, 9, 2'b00, 3'd0, 1'b1, 1'b0, 9'd0);
    run_case("isolation", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1,
             9, 9, 2'b00, 3'd0, 1'b0, 1'b0, 9'd0);
    run_case("conflict", mk(1, 1, 1, 0, 0, 0, 2, 2, 2), 1'b0,
             2, 9, 2'b01, 3'd0, 1'b0, 1'b1, 9'b000000111);
    run_case("invalid_cells", mk(3, 3, 3, 3, 3, 3, 3, 3, 3), 1'b0,
             9, 9, 2'b00, 3'd0, 1'b1, 1'b0, 9'd0);
    run_case("col_mid", mk(0, 2, 0, 0, 2, 0, 0, 2, 1), 1'b0,
             6, 9, 2'b10, 3'd4, 1'b0, 1'b0, 9'b010010010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
